sha256_double_search: RTL and testbench
=======================================

// Module: sha256_double_search
// PURPOSE
//  Multi-lane double-SHA256 nonce search engine. Accepts one job: block, midstate, nonce base, nonce count, target.
//  Hashes NUM_LANES candidate nonces per round and stops at the first hash strictly below target, or when the range is exhausted.
//  Adds a ready/valid job handshake, bounded range, abort and an explicit not-found result.
//  Sits between the job dispatcher and the result collector.
// PARAMETERS
//  NUM_LANES  2   parallel sha256_double_lane instances, >=1
//  NONCE_OFS  12  byte index in block where the 4-byte nonce is inserted, 0..60
//  CNT_W      32  width of nonce count and tried counters
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       asynchronous reset, active-low
//  in_valid        in   1       job offered
//  in_ready        out  1       job accepted when in_valid&&in_ready
//  in_abort        in   1       cancel current job
//  in_data         in   64x8    block; bytes [NONCE_OFS+:4] replaced by nonce
//  in_state        in   8x32    midstate for first compression
//  in_nonce_base   in   32      first nonce
//  in_nonce_count  in   CNT_W   number of nonces to try
//  in_target       in   32x8    success when digest < target (unsigned, packed order)
//  out_valid       out  1       one-cycle pulse: job finished
//  out_found       out  1       1 = nonce found, 0 = range exhausted
//  out_nonce       out  32      winning nonce (0 if not found)
//  out_result      out  32x8    winning digest (0 if not found)
//  out_tried       out  CNT_W   nonces hashed and compared
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0. FSM=IDLE. Lanes idle. After release in_ready=1.
//  Job inputs are registered on accept; later changes are ignored until the next accept.
//  FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
//   IDLE:  in_ready=1. On accept: latch job; cur=base; remaining=count; tried=0.
//          count==0 -> DONE; otherwise -> ISSUE.
//   ISSUE (1 cycle): lane i gets start iff i<remaining; lane i nonce = cur+i (mod 2^32, wrap silent).
//          n=min(NUM_LANES, remaining). -> WAIT.
//   WAIT:  hold until every started lane asserts done.
//          Then tried+=n, remaining-=n, cur+=n.
//          Any started lane with hash<target: the lowest lane index wins (lowest nonce) -> DONE, found=1.
//          Else remaining==0 -> DONE, found=0. Else -> ISSUE.
//   DONE (1 cycle): out_valid=1; out_found, out_nonce, out_result, out_tried updated -> IDLE.
//          Outputs other than out_valid hold until the next DONE.
//   DRAIN: in_ready=0; wait for all lanes idle, discard their results -> IDLE. No out_valid.
//  in_abort:
//   ISSUE/WAIT -> DRAIN, with no out_valid.
//   Abort beats the success/exhaust decision in the same cycle.
//   In IDLE, abort with in_valid: abort ignored, job accepted.
//   In DONE: abort ignored.
//  in_valid while in_ready=0 is ignored (not queued).
//  in_ready is combinational from FSM state only. Every other output is registered.
//  Compare: 256-bit unsigned, out_result[31] is MSB byte. Equality is not success.
//  out_tried counts every lane in the final round, including lanes above the winner.
//  Lane latency is fixed by tumble+sha256 and is not assumed constant by the FSM (done-based).
// STRUCTURE
//  sha256_pkg:
//   block_t = logic[63:0][7:0]
//   state_t = logic[7:0][31:0]
//   digest_t = logic[31:0][7:0]
//   fsm enum
//   SHA256_IV constant
//  Sub-module sha256_double_lane(clk, rst_n, start, block, state, nonce, busy, done, hash):
//   inserts nonce, runs tumble then sha256, pulses done with hash held.
//   Drives the sub-blocks' active-high rst as ~rst_n.
//  Top module: FSM, counters, lane generate loop, priority winner select.
// TESTING
//  1 LANES=2, target all-ones, base 0x100, count 10 -> out_found=1, out_nonce=0x100, out_tried=2.
//  2 target=0, base 7, count 5 -> 3 rounds, lane1 idle in round 3; out_found=0, out_tried=5, out_nonce=0.
//  3 count=0 -> out_valid 2 cycles after accept, found=0, tried=0; lanes never started.
//  4 Known-solution block, base=sol-3, target=its digest+1 -> out_nonce=sol, out_result=golden digest, out_tried=4.
//  5 Abort in WAIT -> no out_valid; in_ready low until lanes idle; next job (case 1) passes.
//  6a base 0xFFFFFFFF, count 3, target 0 -> nonces FFFFFFFF,0,1 hashed (checked vs model), tried=3.
//  6b rst_n low mid-WAIT -> outputs 0 immediately; after release case 1 passes.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types, constants and round helpers for the double-SHA256 nonce search engine.
package sha256_pkg;

    typedef logic [63:0][7:0]  block_t;
    typedef logic [7:0][31:0]  state_t;
    typedef logic [31:0][7:0]  digest_t;
    typedef logic [15:0][31:0] sched_t;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} fsm_t;

    // state_t[7] holds H0, so a state cast to 256 bits reads as the big-endian digest
    localparam state_t SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][31:0] SHA256_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Byte 0 of the block is the first message byte; sched_t[15] is W0
    function automatic sched_t block_words(input block_t b);
        sched_t r;
        for (int j = 0; j < 16; j++) begin
            r[15-j] = {b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]};
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_double_search_lane.sv
// One hashing lane: inserts the nonce (little-endian) into the block, compresses it from the
// midstate, then hashes the 32-byte result again from the IV using one iterative round engine.
module sha256_double_lane
    import sha256_pkg::*;
#(
    parameter int NONCE_OFS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  block_t      block,
    input  state_t      state,
    input  logic [31:0] nonce,
    output logic        busy,
    output logic        done,
    output digest_t     hash
);

    block_t      blk;
    sched_t      w;
    state_t      work, init_h, next_work, sum;
    logic [5:0]  rnd;
    logic        second;
    logic [31:0] t1, t2, w_new;

    // work[7] is 'a' down to work[0] as 'h'; w[15] is the schedule word for the current round
    always_comb begin
        blk = block;
        for (int k = 0; k < 4; k++) begin
            blk[NONCE_OFS+k] = nonce[8*k +: 8];
        end
        t1 = work[0] + bsig1(work[3]) + ch(work[3], work[2], work[1]) + SHA256_K[rnd] + w[15];
        t2 = bsig0(work[7]) + maj(work[7], work[6], work[5]);
        next_work = {t1 + t2, work[7:5], work[4] + t1, work[3:1]};
        for (int i = 0; i < 8; i++) begin
            sum[i] = init_h[i] + next_work[i];
        end
        w_new = ssig1(w[1]) + w[6] + ssig0(w[14]) + w[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            second <= 1'b0;
            rnd    <= '0;
            w      <= '0;
            work   <= '0;
            init_h <= '0;
            hash   <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    w      <= block_words(blk);
                    work   <= state;
                    init_h <= state;
                    rnd    <= '0;
                    second <= 1'b0;
                    busy   <= 1'b1;
                end
            end else begin
                rnd <= rnd + 6'd1;
                if (rnd != 6'd63) begin
                    work <= next_work;
                    w    <= {w[14:0], w_new};
                end else if (!second) begin
                    // Second pass: 32-byte digest, 0x80 pad, 256-bit length
                    w      <= {sum, 32'h8000_0000, 192'd0, 32'h0000_0100};
                    work   <= SHA256_IV;
                    init_h <= SHA256_IV;
                    second <= 1'b1;
                end else begin
                    hash <= digest_t'(sum);
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sha256_double_search.sv
// Multi-lane double-SHA256 nonce search: takes one job, sweeps the nonce range NUM_LANES at a
// time and reports the lowest nonce whose digest is strictly below target, or a not-found result.
module sha256_double_search
    import sha256_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int NONCE_OFS = 12,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_abort,
    input  logic [63:0][7:0]      in_data,
    input  logic [7:0][31:0]      in_state,
    input  logic [31:0]           in_nonce_base,
    input  logic [CNT_W-1:0]      in_nonce_count,
    input  logic [31:0][7:0]      in_target,
    output logic                  out_valid,
    output logic                  out_found,
    output logic [31:0]           out_nonce,
    output logic [31:0][7:0]      out_result,
    output logic [CNT_W-1:0]      out_tried
);

    fsm_t                 state, state_nxt;
    block_t               job_block;
    state_t               job_mid;
    digest_t              job_target;
    logic [31:0]          cur;
    logic [CNT_W-1:0]     remaining, tried, n_issued, n;
    logic [NUM_LANES-1:0] lane_start, lane_busy, lane_done, started, pending;
    digest_t              lane_hash [NUM_LANES];
    logic                 hit, accept, decide;
    logic [31:0]          win_nonce;
    digest_t              win_hash;
    logic                 res_found;
    logic [31:0]          res_nonce;
    digest_t              res_hash;

    assign in_ready = rst_n && (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign decide   = (state == S_WAIT) && !in_abort && (pending == '0);

    // Lane issue mask and round size; the descending loop leaves the lowest winning lane selected
    always_comb begin
        lane_start = '0;
        hit        = 1'b0;
        win_nonce  = '0;
        win_hash   = '0;
        n = (remaining < CNT_W'(NUM_LANES)) ? remaining : CNT_W'(NUM_LANES);
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_start[i] = (state == S_ISSUE) && !in_abort && (CNT_W'(i) < remaining);
        end
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (started[i] && (lane_hash[i] < job_target)) begin
                hit       = 1'b1;
                win_nonce = cur + 32'(i);
                win_hash  = lane_hash[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (in_nonce_count == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: state_nxt = in_abort ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (in_abort) begin
                    state_nxt = S_DRAIN;
                end else if (pending == '0) begin
                    state_nxt = (hit || (remaining == n_issued)) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_DRAIN: if (lane_busy == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_block  <= '0;
            job_mid    <= '0;
            job_target <= '0;
            cur        <= '0;
            remaining  <= '0;
            tried      <= '0;
            n_issued   <= '0;
            started    <= '0;
            pending    <= '0;
            res_found  <= 1'b0;
            res_nonce  <= '0;
            res_hash   <= '0;
            out_valid  <= 1'b0;
            out_found  <= 1'b0;
            out_nonce  <= '0;
            out_result <= '0;
            out_tried  <= '0;
        end else begin
            if (accept) begin
                job_block  <= in_data;
                job_mid    <= in_state;
                job_target <= in_target;
                cur        <= in_nonce_base;
                remaining  <= in_nonce_count;
                tried      <= '0;
                res_found  <= 1'b0;
                res_nonce  <= '0;
                res_hash   <= '0;
            end
            if (state == S_ISSUE) begin
                started  <= lane_start;
                pending  <= lane_start;
                n_issued <= n;
            end else begin
                pending <= pending & ~lane_done;
            end
            if (decide) begin
                tried     <= tried + n_issued;
                remaining <= remaining - n_issued;
                cur       <= cur + 32'(n_issued);
                if (hit) begin
                    res_found <= 1'b1;
                    res_nonce <= win_nonce;
                    res_hash  <= win_hash;
                end
            end
            out_valid <= (state == S_DONE);
            if (state == S_DONE) begin
                out_found  <= res_found;
                out_nonce  <= res_nonce;
                out_result <= res_hash;
                out_tried  <= tried;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sha256_double_lane #(.NONCE_OFS(NONCE_OFS)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .start (lane_start[g]),
            .block (job_block),
            .state (job_mid),
            .nonce (cur + 32'(g)),
            .busy  (lane_busy[g]),
            .done  (lane_done[g]),
            .hash  (lane_hash[g])
        );
    end

endmodule

// File: tb/tb_sha256_double_search.sv
// Directed bench for sha256_double_search with an independent behavioural double-SHA256 model.
module tb_sha256_double_search;
    import sha256_pkg::*;

    localparam int NUM_LANES = 2;
    localparam int NONCE_OFS = 12;
    localparam int CNT_W     = 32;

    logic             clk, rst_n, in_valid, in_ready, in_abort;
    block_t           in_data;
    state_t           in_state;
    logic [31:0]      in_nonce_base;
    logic [CNT_W-1:0] in_nonce_count;
    digest_t          in_target;
    logic             out_valid, out_found;
    logic [31:0]      out_nonce;
    digest_t          out_result;
    logic [CNT_W-1:0] out_tried;

    int errors = 0;
    int checks = 0;

    block_t      test_block;
    state_t      test_mid;
    logic [31:0] abc_msg [16];

    sha256_double_search #(.NUM_LANES(NUM_LANES), .NONCE_OFS(NONCE_OFS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_abort(in_abort),
        .in_data(in_data), .in_state(in_state), .in_nonce_base(in_nonce_base),
        .in_nonce_count(in_nonce_count), .in_target(in_target), .out_valid(out_valid),
        .out_found(out_found), .out_nonce(out_nonce), .out_result(out_result), .out_tried(out_tried)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic state_t compressModel(input state_t hin, input logic [31:0] m [16]);
        logic [31:0] wexp [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) wexp[t] = m[t];
        for (int t = 16; t < 64; t++) begin
            wexp[t] = (rr(wexp[t-2], 17) ^ rr(wexp[t-2], 19) ^ (wexp[t-2] >> 10)) + wexp[t-7]
                    + (rr(wexp[t-15], 7) ^ rr(wexp[t-15], 18) ^ (wexp[t-15] >> 3)) + wexp[t-16];
        end
        a = hin[7]; b = hin[6]; c = hin[5]; d = hin[4];
        e = hin[3]; f = hin[2]; g = hin[1]; h = hin[0];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + SHA256_K[t] + wexp[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[7] + a, hin[6] + b, hin[5] + c, hin[4] + d, hin[3] + e, hin[2] + f, hin[1] + g, hin[0] + h};
    endfunction

    function automatic digest_t modelHash(input block_t blk, input state_t mid, input logic [31:0] nonce);
        block_t      bb;
        logic [31:0] m [16];
        state_t      s;
        bb = blk;
        for (int k = 0; k < 4; k++) bb[NONCE_OFS+k] = nonce[8*k +: 8];
        for (int j = 0; j < 16; j++) m[j] = {bb[4*j], bb[4*j+1], bb[4*j+2], bb[4*j+3]};
        s = compressModel(mid, m);
        for (int j = 0; j < 8; j++) m[j] = s[7-j];
        m[8] = 32'h8000_0000;
        for (int j = 9; j < 15; j++) m[j] = 32'h0;
        m[15] = 32'd256;
        return digest_t'(compressModel(SHA256_IV, m));
    endfunction

    // Offer one job while idle, then scramble the inputs to show they were latched on accept
    task automatic applyStimulus(input logic [31:0] base, input logic [CNT_W-1:0] count, input logic [255:0] target);
        @(negedge clk);
        checkOutput("ready_before_job", in_ready, 1'b1);
        in_data        = test_block;
        in_state       = test_mid;
        in_nonce_base  = base;
        in_nonce_count = count;
        in_target      = target;
        in_valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid       = 1'b0;
        in_data        = ~test_block;
        in_state       = ~test_mid;
        in_nonce_base  = ~base;
        in_nonce_count = '1;
        in_target      = '0;
    endtask

    task automatic waitResult(input string tag, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_valid"}, got, 1'b1);
    endtask

    task automatic runJob(input string tag, input logic [31:0] base, input logic [CNT_W-1:0] count,
                          input logic [255:0] target, input logic exp_found, input logic [31:0] exp_nonce,
                          input logic [255:0] exp_result, input logic [CNT_W-1:0] exp_tried);
        int lat;
        applyStimulus(base, count, target);
        waitResult(tag, lat);
        checkOutput({tag, "_found"}, out_found, exp_found);
        checkOutput({tag, "_nonce"}, out_nonce, exp_nonce);
        checkOutput({tag, "_result"}, out_result, exp_result);
        checkOutput({tag, "_tried"}, out_tried, exp_tried);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, out_valid, 1'b0);
        checkOutput({tag, "_hold"}, out_tried, exp_tried);
    endtask

    initial begin
        logic [31:0] sol, exp_nonce;
        logic        sol_ok, saw_valid, ready_seen;
        digest_t     d0, d1, d2, d3, sol_hash, dmin;
        int          lat, drain_cycles, min_idx;

        rst_n = 1'b0; in_valid = 1'b0; in_abort = 1'b0;
        in_data = '0; in_state = '0; in_nonce_base = '0; in_nonce_count = '0; in_target = '0;
        for (int i = 0; i < 64; i++) test_block[i] = 8'(i * 13 + 5);
        test_mid = SHA256_IV ^ {8{32'h0123_4567}};

        #1;
        checkOutput("reset_ready", in_ready, 1'b0);
        checkOutput("reset_valid", out_valid, 1'b0);
        checkOutput("reset_tried", out_tried, '0);
        checkOutput("reset_result", out_result, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", in_ready, 1'b1);

        // Model sanity against the published SHA256("abc") digest
        for (int j = 0; j < 16; j++) abc_msg[j] = 32'h0;
        abc_msg[0]  = 32'h6162_6380;
        abc_msg[15] = 32'h0000_0018;
        checkOutput("model_abc", compressModel(SHA256_IV, abc_msg),
                    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        runJob("first_hit", 32'h100, 10, '1, 1'b1, 32'h100, modelHash(test_block, test_mid, 32'h100), 2);
        runJob("exhaust", 32'h7, 5, '0, 1'b0, 32'h0, '0, 5);

        applyStimulus(32'h55, 0, '1);
        waitResult("count_zero", lat);
        checkOutput("count_zero_latency", lat, 1);
        checkOutput("count_zero_found", out_found, 1'b0);
        checkOutput("count_zero_tried", out_tried, '0);
        checkOutput("count_zero_nonce", out_nonce, '0);

        d0 = modelHash(test_block, test_mid, 32'h42);
        runJob("equal_not_hit", 32'h42, 1, d0, 1'b0, 32'h0, '0, 1);

        sol_ok = 1'b0; sol = '0; sol_hash = '0;
        for (int c = 0; c < 200 && !sol_ok; c++) begin
            d0 = modelHash(test_block, test_mid, 32'h1000 + 32'(c));
            d1 = modelHash(test_block, test_mid, 32'h1001 + 32'(c));
            d2 = modelHash(test_block, test_mid, 32'h1002 + 32'(c));
            d3 = modelHash(test_block, test_mid, 32'h1003 + 32'(c));
            if (d3 < d0 && d3 < d1 && d3 < d2) begin
                sol_ok = 1'b1;
                sol = 32'h1003 + 32'(c);
                sol_hash = d3;
            end
        end
        checkOutput("solution_search", sol_ok, 1'b1);
        runJob("known_solution", sol - 32'd3, 8, sol_hash + 256'd1, 1'b1, sol, sol_hash, 4);

        applyStimulus(32'h500, 10, '0);
        repeat (20) @(negedge clk);
        checkOutput("abort_no_early_valid", out_valid, 1'b0);
        in_abort = 1'b1;
        @(negedge clk);
        in_abort = 1'b0;
        checkOutput("abort_ready_low", in_ready, 1'b0);
        in_valid = 1'b1; in_nonce_count = '0;
        saw_valid = 1'b0; ready_seen = 1'b0; drain_cycles = 0;
        for (int c = 0; c < 1000; c++) begin
            if (out_valid) saw_valid = 1'b1;
            if (in_ready) begin
                ready_seen = 1'b1;
                break;
            end
            drain_cycles++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("abort_no_valid", saw_valid, 1'b0);
        checkOutput("abort_ready_returns", ready_seen, 1'b1);
        checkOutput("abort_drain_waited", drain_cycles >= 20, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("abort_no_queued_job", out_valid, 1'b0);
        end
        runJob("after_abort", 32'h100, 10, '1, 1'b1, 32'h100, modelHash(test_block, test_mid, 32'h100), 2);

        runJob("wrap_exhaust", 32'hFFFF_FFFF, 3, '0, 1'b0, 32'h0, '0, 3);
        d0 = modelHash(test_block, test_mid, 32'hFFFF_FFFF);
        d1 = modelHash(test_block, test_mid, 32'h0000_0000);
        d2 = modelHash(test_block, test_mid, 32'h0000_0001);
        dmin = d0; min_idx = 0;
        if (d1 < dmin) begin dmin = d1; min_idx = 1; end
        if (d2 < dmin) begin dmin = d2; min_idx = 2; end
        exp_nonce = 32'hFFFF_FFFF + 32'(min_idx);
        runJob("wrap_hit", 32'hFFFF_FFFF, 3, dmin + 256'd1, 1'b1, exp_nonce, dmin, (min_idx < 2) ? 2 : 3);

        applyStimulus(32'h900, 10, '0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", in_ready, 1'b0);
        checkOutput("midrst_valid", out_valid, 1'b0);
        checkOutput("midrst_found", out_found, 1'b0);
        checkOutput("midrst_nonce", out_nonce, '0);
        checkOutput("midrst_result", out_result, '0);
        checkOutput("midrst_tried", out_tried, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_after", in_ready, 1'b1);
        runJob("after_reset", 32'h100, 10, '1, 1'b1, 32'h100, modelHash(test_block, test_mid, 32'h100), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
